// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and types for the polynomial datapath.
// Holds modulus, centering bound, polynomial size, coefficient width.
package dilithium_pkg;

    localparam int unsigned DIL_Q      = 8380417;
    localparam int unsigned DIL_Q_HALF = (DIL_Q - 1) / 2;
    localparam int unsigned DIL_N      = 256;
    localparam int unsigned COEF_W     = 23;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_RUN,
        PS_DRAIN
    } ps_state_t;

endpackage

// File: rtl/axis_credit_fifo.sv
// Small synchronous FIFO for the stream output buffer.
// Ports: clk, rst_n, clr, push/din, pop/dout, empty, count (occupancy).
module axis_credit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign dout   = mem[rp];

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)   wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/poly_stream_out.sv
// Streams a polynomial from dual-port coefficient RAM to the AXI-stream FIFO,
// two coefficients per beat. Ports: start/centered/busy/done, RAM A/B, Write_FIFO_*.
module poly_stream_out
    import dilithium_pkg::*;
#(
    parameter int unsigned Q         = DIL_Q,
    parameter int unsigned N_COEF    = DIL_N,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              centered,
    output logic              busy,
    output logic              done,
    output logic              coef_ena,
    output logic [7:0]        coef_addra,
    input  logic [COEF_W-1:0] coef_douta,
    output logic              coef_enb,
    output logic [7:0]        coef_addrb,
    input  logic [COEF_W-1:0] coef_doutb,
    output logic              coef_wea,
    output logic              coef_web,
    output logic              Write_FIFO_tvalid,
    input  logic              Write_FIFO_tready,
    output logic [63:0]       Write_FIFO_tdata,
    output logic [7:0]        Write_FIFO_tkeep,
    output logic              Write_FIFO_tlast
);

    localparam int unsigned NB   = N_COEF / 2;
    localparam int unsigned RKW  = $clog2(NB) + 1;
    localparam int unsigned CW   = $clog2(BUF_DEPTH) + 1;
    localparam logic [31:0] HALF = 32'((Q - 1) / 2);

    function automatic logic [31:0] center(
        input logic [COEF_W-1:0] c,
        input logic              m
    );
        logic [31:0] z;
        z = 32'(c);
        // 32-bit wrap of z - Q is the sign-extended negative value
        if (m && (z > HALF)) return z - 32'(Q);
        return z;
    endfunction

    ps_state_t      state_q;
    ps_state_t      state_d;
    logic [RKW-1:0] rk_q;
    logic           pend_q;
    logic           mode_q;
    logic           done_q;
    logic           issue;
    logic           clr;
    logic           pop;
    logic           last_hs;
    logic           empty;
    logic [CW-1:0]  occ;
    logic [64:0]    din;
    logic [64:0]    head;

    // Credit: buffered beats plus the pair still in the RAM pipeline
    assign issue = (state_q == PS_RUN) &&
                   ((32'(occ) + 32'(pend_q)) < BUF_DEPTH);
    assign clr   = (state_q == PS_IDLE) && start;

    assign Write_FIFO_tvalid = !empty;
    assign pop     = Write_FIFO_tvalid && Write_FIFO_tready;
    assign last_hs = pop && head[64];

    // rk has already advanced past the pair now returning from RAM
    assign din = {rk_q == RKW'(NB),
                  center(coef_doutb, mode_q),
                  center(coef_douta, mode_q)};

    axis_credit_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (65)
    ) u_buf (
        .clk   (clk),
        .rst_n (aresetn),
        .clr   (clr),
        .push  (pend_q),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .count (occ)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PS_IDLE:  if (start) state_d = PS_RUN;
            PS_RUN:   if (issue && (rk_q == RKW'(NB - 1))) state_d = PS_DRAIN;
            PS_DRAIN: if (last_hs) state_d = PS_IDLE;
            default:  state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= PS_IDLE;
            rk_q    <= '0;
            pend_q  <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= issue;
            done_q  <= last_hs;
            if (clr) begin
                rk_q   <= '0;
                mode_q <= centered;
            end else if (issue) begin
                rk_q <= rk_q + 1'b1;
            end
        end
    end

    assign busy       = (state_q != PS_IDLE);
    assign done       = done_q;
    assign coef_ena   = issue;
    assign coef_enb   = issue;
    assign coef_addra = issue ? {rk_q[RKW-2:0], 1'b0} : 8'd0;
    assign coef_addrb = issue ? {rk_q[RKW-2:0], 1'b1} : 8'd0;
    assign coef_wea   = 1'b0;
    assign coef_web   = 1'b0;

    assign Write_FIFO_tdata = Write_FIFO_tvalid ? head[63:0] : 64'd0;
    assign Write_FIFO_tlast = Write_FIFO_tvalid && head[64];
    assign Write_FIFO_tkeep = 8'hFF;

endmodule

// File: tb/tb_poly_stream_out.sv
// Self-checking bench for poly_stream_out with a scoreboard queue.
// Drives a behavioural dual-port RAM and a randomised stream sink.
module tb_poly_stream_out;

    localparam int NB  = 128;
    localparam int LIM = 4000;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        centered = 1'b0;
    logic        tready = 1'b0;
    logic        busy, done;
    logic        coef_ena, coef_enb, coef_wea, coef_web;
    logic [7:0]  coef_addra, coef_addrb;
    logic [22:0] douta = '0;
    logic [22:0] doutb = '0;
    logic        tvalid, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    int n_cmp = 0;
    int n_bad = 0;
    int issued = 0;
    int popped = 0;

    logic [22:0] ram [256];
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    poly_stream_out dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .start             (start),
        .centered          (centered),
        .busy              (busy),
        .done              (done),
        .coef_ena          (coef_ena),
        .coef_addra        (coef_addra),
        .coef_douta        (douta),
        .coef_enb          (coef_enb),
        .coef_addrb        (coef_addrb),
        .coef_doutb        (doutb),
        .coef_wea          (coef_wea),
        .coef_web          (coef_web),
        .Write_FIFO_tvalid (tvalid),
        .Write_FIFO_tready (tready),
        .Write_FIFO_tdata  (tdata),
        .Write_FIFO_tkeep  (tkeep),
        .Write_FIFO_tlast  (tlast)
    );

    always @(posedge clk) begin
        if (coef_ena) douta <= ram[coef_addra];
        if (coef_enb) doutb <= ram[coef_addrb];
    end

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            issued <= 0;
            popped <= 0;
        end else begin
            if (coef_ena) issued <= issued + 1;
            if (tvalid && tready) popped <= popped + 1;
        end
    end

    function automatic logic [31:0] ref_conv(input logic [22:0] c, input bit cen);
        int v;
        v = int'({9'd0, c});
        if (cen && v > 4190208) v = v - 8380417;
        return 32'(v);
    endfunction

    task automatic load_expected(input bit cen);
        for (int k = 0; k < NB; k++)
            exp_q.push_back({k == NB - 1,
                             ref_conv(ram[2*k+1], cen),
                             ref_conv(ram[2*k], cen)});
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++)
            ram[i] = 23'($urandom_range(0, 8380416));
    endtask

    // Called at a negedge: start sampled at the following posedge (edge 0)
    task automatic kick(input bit cen);
        start = 1'b1;
        centered = cen;
        load_expected(cen);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        centered = ~cen;
    endtask

    // One clock: set tready, sample the beat, cross a posedge, sample done
    task automatic step(input logic rdy, output bit v, output bit hs,
                        output logic [64:0] beat, output bit dn);
        tready = rdy;
        #1;
        v = tvalid;
        hs = tvalid && rdy;
        beat = {tlast, tdata};
        @(posedge clk);
        @(negedge clk);
        dn = done;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #2;
        n_cmp++;
        if ({busy, done, tvalid, tlast, coef_ena, coef_enb} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, done, tvalid, tlast, coef_ena, coef_enb});
        end
        n_cmp++;
        if (tdata !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_tdata: got %h want 0", tdata);
        end
        n_cmp++;
        if ({coef_addra, coef_addrb, coef_wea, coef_web, tkeep} !== {18'd0, 8'hFF}) begin
            n_bad++;
            $display("FAIL reset_ram_if: got %h want %h",
                     {coef_addra, coef_addrb, coef_wea, coef_web, tkeep}, {18'd0, 8'hFF});
        end
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        bit v, hs, dn;
        logic [64:0] b, e;
        int ed = 0, beats = 0, dones = 0, done_ed = -1, first_ed = -1;
        for (int i = 0; i < 256; i++) ram[i] = 23'(i);
        kick(1'b0);
        while (dones == 0 && ed < LIM) begin
            step(1'b1, v, hs, b, dn);
            ed++;
            if (hs) begin
                if (first_ed < 0) first_ed = ed;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                n_cmp++;
                if (b !== e) begin
                    n_bad++;
                    $display("FAIL ramp_beat %0d: got %h want %h", beats, b, e);
                end
                beats++;
            end
            if (dn) begin
                dones++;
                done_ed = ed;
            end
        end
        n_cmp++;
        if (beats != NB || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ramp_count: got %0d beats want %0d", beats, NB);
        end
        n_cmp++;
        if (first_ed != 3) begin
            n_bad++;
            $display("FAIL ramp_first_hs: got edge %0d want 3", first_ed);
        end
        // Beat k handshakes at edge 3+k; done follows beat 127 at edge 130
        n_cmp++;
        if (done_ed != 130) begin
            n_bad++;
            $display("FAIL ramp_done_edge: got %0d want 130", done_ed);
        end
        exp_q.delete();
    endtask

    task automatic test_centered();
        bit v, hs, dn;
        logic [64:0] b, e;
        int ed = 0, beats = 0, dones = 0;
        fill_random();
        ram[0] = 23'd4190208;
        ram[1] = 23'd4190209;
        ram[2] = 23'd8380416;
        ram[3] = 23'd0;
        kick(1'b1);
        while (dones == 0 && ed < LIM) begin
            step(1'b1, v, hs, b, dn);
            ed++;
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                if (beats == 0) e = {1'b0, 64'hFFC01000_003FF000};
                if (beats == 1) e = {1'b0, 64'h00000000_FFFFFFFF};
                n_cmp++;
                if (b !== e) begin
                    n_bad++;
                    $display("FAIL cent_beat %0d: got %h want %h", beats, b, e);
                end
                beats++;
            end
            if (dn) dones++;
        end
        n_cmp++;
        if (beats != NB || dones != 1) begin
            n_bad++;
            $display("FAIL cent_count: got %0d/%0d want %0d/1", beats, dones, NB);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit v, hs, dn, held;
        logic rdy;
        logic [64:0] b, e, prev;
        int ed = 0, beats = 0, dones = 0, stall = -1;
        fill_random();
        held = 1'b0;
        prev = '0;
        kick(1'b0);
        while (dones == 0 && ed < LIM) begin
            if (beats == 60 && stall < 0) stall = 20;
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            step(rdy, v, hs, b, dn);
            ed++;
            if (held) begin
                n_cmp++;
                if (!v || b !== prev) begin
                    n_bad++;
                    $display("FAIL bp_stable: got %b/%h want 1/%h", v, b, prev);
                end
            end
            held = v && !rdy;
            prev = b;
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                n_cmp++;
                if (b !== e) begin
                    n_bad++;
                    $display("FAIL bp_beat %0d: got %h want %h", beats, b, e);
                end
                beats++;
            end
            n_cmp++;
            if (issued - popped > 4 || issued - popped < 0) begin
                n_bad++;
                $display("FAIL bp_occupancy: got %0d want 0..4", issued - popped);
            end
            if (dn) dones++;
        end
        n_cmp++;
        if (beats != NB || dones != 1 || stall != 0) begin
            n_bad++;
            $display("FAIL bp_count: got %0d/%0d want %0d/1", beats, dones, NB);
        end
        exp_q.delete();
    endtask

    task automatic test_restart_ignored();
        bit v, hs, dn;
        logic [64:0] b, e;
        int ed = 0, beats = 0, dones = 0;
        bit pulsed = 1'b0;
        fill_random();
        kick(1'b1);
        while (ed < 300) begin
            if (beats == 40 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            step(1'b1, v, hs, b, dn);
            start = 1'b0;
            ed++;
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                n_cmp++;
                if (b !== e) begin
                    n_bad++;
                    $display("FAIL rst_ign_beat %0d: got %h want %h", beats, b, e);
                end
                beats++;
            end
            if (dn) dones++;
        end
        n_cmp++;
        if (beats != NB || dones != 1) begin
            n_bad++;
            $display("FAIL rst_ign_count: got %0d/%0d want %0d/1", beats, dones, NB);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit v, hs, dn;
        logic [64:0] b, e;
        int ed = 0, beats = 0, dones = 0;
        fill_random();
        kick(1'b0);
        while (beats < 70 && ed < LIM) begin
            step(1'($urandom_range(0, 1)), v, hs, b, dn);
            ed++;
            if (hs) beats++;
            if (dn) dones++;
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, tvalid, tlast, coef_ena, coef_enb} !== 6'b0 || tdata !== 64'd0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b/%h want 000000/0",
                     {busy, done, tvalid, tlast, coef_ena, coef_enb}, tdata);
        end
        n_cmp++;
        if (dones != 0 || ed >= LIM) begin
            n_bad++;
            $display("FAIL abort_done: got %0d want 0", dones);
        end
        exp_q.delete();
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        fill_random();
        ed = 0;
        beats = 0;
        kick(1'b1);
        while (dones == 0 && ed < LIM) begin
            step(1'b1, v, hs, b, dn);
            ed++;
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                n_cmp++;
                if (b !== e) begin
                    n_bad++;
                    $display("FAIL fresh_beat %0d: got %h want %h", beats, b, e);
                end
                beats++;
            end
            if (dn) dones++;
        end
        n_cmp++;
        if (beats != NB || dones != 1) begin
            n_bad++;
            $display("FAIL fresh_count: got %0d/%0d want %0d/1", beats, dones, NB);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit v, hs, dn;
        logic [64:0] b, e;
        int ed, beats, dones;
        for (int x = 0; x < 2; x++) begin
            ed = 0;
            beats = 0;
            dones = 0;
            fill_random();
            kick(x == 1);
            while (dones == 0 && ed < LIM) begin
                step(1'($urandom_range(0, 3) != 0), v, hs, b, dn);
                ed++;
                if (hs) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
                    n_cmp++;
                    if (b !== e) begin
                        n_bad++;
                        $display("FAIL b2b%0d_beat %0d: got %h want %h", x, beats, b, e);
                    end
                    beats++;
                end
                if (dn) dones++;
            end
            n_cmp++;
            if (beats != NB || dones != 1) begin
                n_bad++;
                $display("FAIL b2b%0d_count: got %0d/%0d want %0d/1", x, beats, dones, NB);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d_busy_gap: got %b want 0", x, busy);
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_centered();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
